// File: rtl/rst_sequencer.sv
// Multi-domain reset sequencer: staggered power-on release of NUM_DOMAINS resets,
// then one-at-a-time software re-resets under round-robin arbitration.
module rst_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic [NUM_DOMAINS-1:0] ack,
  output logic                   ready,
  output logic                   busy
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_DOMAINS);

  localparam logic [1:0] S_POR_HOLD    = 2'd0;
  localparam logic [1:0] S_POR_STAGGER = 2'd1;
  localparam logic [1:0] S_RUN         = 2'd2;
  localparam logic [1:0] S_SERVICE     = 2'd3;

  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] ONE       = NUM_DOMAINS'(1);

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       ptr;
  logic [NUM_DOMAINS-1:0] pending;

  logic                   grant_valid;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       cand;

  // Round-robin search: first pending domain strictly after the last one granted.
  // NOTE: every output of this block gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_DOMAINS; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_DOMAINS);
      if (!grant_valid && pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // NOTE: state uses non-blocking assignments; a later assignment to the same
  // register in this block overrides an earlier default (used for ack and pending).
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_POR_HOLD;
      cnt     <= '0;
      idx     <= '0;
      ptr     <= LAST_IDX;
      pending <= '0;
      rst_out <= '1;
      ack     <= '0;
      ready   <= 1'b0;
      busy    <= 1'b1;
    end else begin
      ack     <= '0;
      pending <= pending | sw_rst_req;
      case (state)
        S_POR_HOLD: begin
          if (cnt == HOLD_LAST) begin
            rst_out[0] <= 1'b0;
            cnt        <= '0;
            idx        <= IDX_W'(1);
            state      <= S_POR_STAGGER;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_POR_STAGGER: begin
          if (cnt == GAP_LAST) begin
            rst_out[idx] <= 1'b0;
            cnt          <= '0;
            if (idx == LAST_IDX) begin
              ready <= 1'b1;
              busy  <= 1'b0;
              state <= S_RUN;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (grant_valid) begin
            rst_out[grant_idx] <= 1'b1;
            // A fresh request for the granted domain wins over the clear.
            pending <= (pending & ~(ONE << grant_idx)) | sw_rst_req;
            busy    <= 1'b1;
            ptr     <= grant_idx;
            idx     <= grant_idx;
            cnt     <= '0;
            state   <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (cnt == HOLD_LAST) begin
            rst_out[idx] <= 1'b0;
            ack          <= ONE << idx;
            busy         <= 1'b0;
            state        <= S_RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_POR_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: per-edge expectations are queued when
// stimulus is driven and compared when the matching clock edge has passed.
module tb_rst_sequencer;

  localparam int N = 4;
  localparam int H = 3;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw_rst_req = '0;
  logic [N-1:0] rst_out;
  logic [N-1:0] ack;
  logic         ready;
  logic         busy;

  rst_sequencer #(
    .NUM_DOMAINS(N),
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_rst_req(sw_rst_req),
    .rst_out   (rst_out),
    .ack       (ack),
    .ready     (ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           edge_no;
    logic [N-1:0] rst_out;
    logic [N-1:0] ack;
    logic         ready;
    logic         busy;
  } exp_t;

  typedef struct {
    int           ofs;
    logic [N-1:0] rst_out;
    logic         ready;
    logic         busy;
  } por_vec_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_at(input int e, input logic [N-1:0] ro, input logic [N-1:0] ak,
                           input logic rdy, input logic bsy);
    exp_t x;
    x.edge_no = e;
    x.rst_out = ro;
    x.ack     = ak;
    x.ready   = rdy;
    x.busy    = bsy;
    exp_q.push_back(x);
  endtask

  // A complete software reset of mask m granted at edge e.
  task automatic exp_service(input int e, input logic [N-1:0] m);
    for (int k = 0; k < H; k++) expect_at(e + k, m, '0, 1'b1, 1'b1);
    expect_at(e + H, '0, m, 1'b1, 1'b0);
  endtask

  // Drive inputs at the falling edge; e is the rising edge that samples them.
  task automatic step(input logic r, input logic [N-1:0] q, output int e);
    @(negedge clk);
    rst        = r;
    sw_rst_req = q;
    e          = cyc + 1;
  endtask

  // Monitor: compare every queued expectation for the edge just passed.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].edge_no == cyc) begin
        exp_t x;
        x = exp_q[i];
        check($sformatf("rst_out@%0d", cyc), 32'(rst_out), 32'(x.rst_out));
        check($sformatf("ack@%0d", cyc),     32'(ack),     32'(x.ack));
        check($sformatf("ready@%0d", cyc),   32'(ready),   32'(x.ready));
        check($sformatf("busy@%0d", cyc),    32'(busy),    32'(x.busy));
        exp_q.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    por_vec_t por_tbl[9];
    int e, r, base;

    // Power-on release, edges relative to the first edge sampling rst=0.
    por_tbl[0] = '{1, 4'b1111, 1'b0, 1'b1};
    por_tbl[1] = '{2, 4'b1111, 1'b0, 1'b1};
    por_tbl[2] = '{3, 4'b1110, 1'b0, 1'b1};
    por_tbl[3] = '{4, 4'b1110, 1'b0, 1'b1};
    por_tbl[4] = '{5, 4'b1100, 1'b0, 1'b1};
    por_tbl[5] = '{6, 4'b1100, 1'b0, 1'b1};
    por_tbl[6] = '{7, 4'b1000, 1'b0, 1'b1};
    por_tbl[7] = '{8, 4'b1000, 1'b0, 1'b1};
    por_tbl[8] = '{9, 4'b0000, 1'b1, 1'b0};

    // Reset held for 5 edges.
    repeat (5) begin
      step(1'b1, '0, e);
      expect_at(e, '1, '0, 1'b0, 1'b1);
    end

    // Power-on sequence.
    step(1'b0, '0, e);
    base = e - 1;
    for (int i = 0; i < 9; i++)
      expect_at(base + por_tbl[i].ofs, por_tbl[i].rst_out, '0, por_tbl[i].ready, por_tbl[i].busy);
    expect_at(base + 10, '0, '0, 1'b1, 1'b0);
    repeat (9) step(1'b0, '0, e);

    // Single request for domain 2.
    step(1'b0, 4'b0100, r);
    expect_at(r, '0, '0, 1'b1, 1'b0);
    exp_service(r + 1, 4'b0100);
    expect_at(r + H + 2, '0, '0, 1'b1, 1'b0);
    repeat (5) step(1'b0, '0, e);

    // Request for domain 0 repeated on its own grant edge: two services.
    step(1'b0, 4'b0001, r);
    expect_at(r, '0, '0, 1'b1, 1'b0);
    step(1'b0, 4'b0001, e);
    exp_service(r + 1, 4'b0001);
    exp_service(r + H + 2, 4'b0001);
    expect_at(r + 2 * H + 3, '0, '0, 1'b1, 1'b0);
    repeat (8) step(1'b0, '0, e);

    // Domain 1 service, then simultaneous 0101 resolved round-robin: 2 before 0.
    step(1'b0, 4'b0010, r);
    expect_at(r, '0, '0, 1'b1, 1'b0);
    exp_service(r + 1, 4'b0010);
    repeat (4) step(1'b0, '0, e);
    step(1'b0, 4'b0101, r);
    expect_at(r, '0, '0, 1'b1, 1'b0);
    exp_service(r + 1, 4'b0100);
    exp_service(r + H + 2, 4'b0001);
    expect_at(r + 2 * H + 3, '0, '0, 1'b1, 1'b0);
    repeat (9) step(1'b0, '0, e);

    // Domain 3 re-requested two edges into its own service.
    step(1'b0, 4'b1000, r);
    expect_at(r, '0, '0, 1'b1, 1'b0);
    exp_service(r + 1, 4'b1000);
    exp_service(r + H + 2, 4'b1000);
    expect_at(r + 2 * H + 3, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, e);
    step(1'b0, '0, e);
    step(1'b0, 4'b1000, e);
    repeat (6) step(1'b0, '0, e);

    // rst one edge into a domain-2 service, with a domain-0 request pending.
    step(1'b0, 4'b0100, r);
    expect_at(r, '0, '0, 1'b1, 1'b0);
    step(1'b0, 4'b0001, e);
    expect_at(e, 4'b0100, '0, 1'b1, 1'b1);
    repeat (3) begin
      step(1'b1, '0, e);
      expect_at(e, '1, '0, 1'b0, 1'b1);
    end

    // Fresh power-on with a domain-1 request at edge 4; only domain 1 is serviced.
    step(1'b0, '0, e);
    base = e - 1;
    for (int i = 0; i < 9; i++)
      expect_at(base + por_tbl[i].ofs, por_tbl[i].rst_out, '0, por_tbl[i].ready, por_tbl[i].busy);
    exp_service(base + 10, 4'b0010);
    for (int k = 14; k <= 20; k++) expect_at(base + k, '0, '0, 1'b1, 1'b0);
    for (int k = 2; k <= 20; k++) step(1'b0, (k == 4) ? 4'b0010 : 4'b0000, e);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
